// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge state encoding and default bus widths.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 requester: a valid/ready command becomes one SETUP/ACCESS
// transfer, and the result is returned on a valid/ready response port.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk_i,
    input  logic              preset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_slverr_o,
    output logic              rsp_timeout_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    apb_state_e        state_q;
    logic [CNT_W-1:0]  tmo_cnt_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_slverr_q;
    logic              rsp_timeout_q;
    logic              tmo_expire;

    assign tmo_expire = (TIMEOUT != 0) && (tmo_cnt_q == CNT_LAST);

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q       <= IDLE;
            tmo_cnt_q     <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        pwrite_q <= cmd_write_i;
                        paddr_q  <= cmd_addr_i;
                        pwdata_q <= cmd_wdata_i;
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    tmo_cnt_q <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // A ready slave takes priority over a timeout expiring on the same edge.
                    if (pready_i) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= pwrite_q ? '0 : prdata_i;
                        rsp_slverr_q  <= pslverr_i;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= RESP;
                    end else if (tmo_expire) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_slverr_q  <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign cmd_ready_o   = (state_q == IDLE) && !preset_i;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_slverr_o  = rsp_slverr_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: behavioural APB memory slave, transaction-level
// reference memory, directed table plus randomized commands and corner sequences.
module tb_apb_master_bridge;

    localparam int TIMEOUT = 16;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic [7:0]  cmd_addr_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_slverr_o;
    logic        rsp_timeout_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [7:0]  paddr_o;
    logic [31:0] pwdata_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;

    apb_master_bridge #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .pclk_i(pclk), .preset_i(preset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_slverr_o(rsp_slverr_o), .rsp_timeout_o(rsp_timeout_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    always #5 pclk = ~pclk;

    // Behavioural APB memory slave with per-transfer wait states, error and hang control.
    int          waitsCfg = 0;
    bit          errCfg = 1'b0;
    bit          hangCfg = 1'b0;
    int          accessCnt = 0;
    logic [31:0] slvMem [256] = '{default: '0};

    assign pready_i  = psel_o && penable_o && !hangCfg && (accessCnt >= waitsCfg);
    assign pslverr_i = errCfg && pready_i;
    assign prdata_i  = slvMem[paddr_o];

    always @(posedge pclk) begin
        if (psel_o && penable_o && !pready_i) accessCnt <= accessCnt + 1;
        else accessCnt <= 0;
        if (psel_o && penable_o && pready_i && pwrite_o && !errCfg) slvMem[paddr_o] <= pwdata_o;
    end

    // Protocol monitor: single-cycle SETUP after a ready handshake, stable address phase.
    int          setupSeen = 0;
    int          protoErr = 0;
    logic        prevReady = 1'b0, prevPsel = 1'b0, prevPen = 1'b0, prevSetup = 1'b0, prevWrite = 1'b0;
    logic [7:0]  prevAddr = '0;
    logic [31:0] prevWdata = '0;

    always @(negedge pclk) begin
        if (psel_o && !penable_o) begin
            setupSeen <= setupSeen + 1;
            if (!prevReady || prevSetup) protoErr <= protoErr + 1;
        end
        if (psel_o && prevPsel && (paddr_o != prevAddr || pwdata_o != prevWdata || pwrite_o != prevWrite))
            protoErr <= protoErr + 1;
        if (penable_o && (!psel_o || (!prevPen && !prevSetup))) protoErr <= protoErr + 1;
        prevReady <= cmd_ready_o;
        prevPsel  <= psel_o;
        prevPen   <= penable_o;
        prevSetup <= psel_o && !penable_o;
        prevAddr  <= paddr_o;
        prevWdata <= pwdata_o;
        prevWrite <= pwrite_o;
    end

    typedef struct {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          waits;
        logic        err;
        logic        hang;
        int          rdyDelay;
        logic [31:0] expRdata;
        logic        expErr;
        logic        expTmo;
        int          expLat;
    } vec_t;

    int          nCompared = 0;
    int          nMismatch = 0;
    logic [31:0] refMem [256];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: transaction-level outcome from the reference memory.
    function automatic vec_t predict(input vec_t v);
        vec_t r = v;
        r.expErr   = v.err || v.hang;
        r.expTmo   = v.hang;
        r.expRdata = (v.write || v.hang) ? 32'h0 : refMem[v.addr];
        r.expLat   = v.hang ? 2 + TIMEOUT : 3 + v.waits;
        return r;
    endfunction

    task automatic commitRef(input vec_t v);
        if (v.write && !v.err && !v.hang) refMem[v.addr] = v.wdata;
    endtask

    task automatic applyStimulus(input vec_t v, output logic [31:0] rdata, output logic err,
                                 output logic tmo, output int lat, output int pen, output int holdBad);
        int  guard;
        bit  seen;
        waitsCfg = v.waits;
        errCfg   = v.err;
        hangCfg  = v.hang;
        @(negedge pclk);
        cmd_valid_i = 1'b1;
        cmd_write_i = v.write;
        cmd_addr_i  = v.addr;
        cmd_wdata_i = v.wdata;
        guard = 0;
        while (!cmd_ready_o && guard < 50) begin
            @(negedge pclk);
            guard++;
        end
        @(negedge pclk);
        cmd_valid_i = 1'b0;
        lat = 1; pen = 0; seen = 1'b0; holdBad = 0;
        while (!seen && lat < 100) begin
            if (penable_o) pen++;
            if (rsp_valid_o) seen = 1'b1;
            else begin
                @(negedge pclk);
                lat++;
            end
        end
        if (!seen) lat = -1;
        rdata = rsp_rdata_o;
        err   = rsp_slverr_o;
        tmo   = rsp_timeout_o;
        for (int i = 0; i < v.rdyDelay; i++) begin
            @(negedge pclk);
            if (!rsp_valid_o || rsp_rdata_o != rdata || rsp_slverr_o != err || rsp_timeout_o != tmo
                || cmd_ready_o || psel_o) holdBad++;
        end
        rsp_ready_i = 1'b1;
        @(negedge pclk);
        rsp_ready_i = 1'b0;
        if (rsp_valid_o || !cmd_ready_o) holdBad++;
        hangCfg = 1'b0;
        errCfg  = 1'b0;
    endtask

    task automatic runAndCheck(input vec_t v, input string tag);
        logic [31:0] rdata;
        logic        err, tmo;
        int          lat, pen, holdBad;
        applyStimulus(v, rdata, err, tmo, lat, pen, holdBad);
        checkOutput({tag, "_rdata"}, rdata, v.expRdata);
        checkOutput({tag, "_slverr"}, 32'(err), 32'(v.expErr));
        checkOutput({tag, "_timeout"}, 32'(tmo), 32'(v.expTmo));
        checkOutput({tag, "_latency"}, 32'(lat), 32'(v.expLat));
        checkOutput({tag, "_penable_cycles"}, 32'(pen), 32'(v.hang ? TIMEOUT : v.waits + 1));
        checkOutput({tag, "_resp_hold"}, 32'(holdBad), 32'd0);
    endtask

    vec_t table_q [$];

    initial begin
        for (int i = 0; i < 256; i++) refMem[i] = '0;

        //           wr    addr   wdata          wt err hang dly  expRdata      eErr eTmo lat
        table_q.push_back('{1'b1, 8'h10, 32'hDEADBEEF, 1, 1'b0, 1'b0, 0, 32'h0,        1'b0, 1'b0, 4});
        table_q.push_back('{1'b0, 8'h10, 32'h0,        0, 1'b0, 1'b0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 3});
        table_q.push_back('{1'b0, 8'h10, 32'h0,        0, 1'b1, 1'b0, 0, 32'hDEADBEEF, 1'b1, 1'b0, 3});
        table_q.push_back('{1'b0, 8'h10, 32'h0,        0, 1'b0, 1'b1, 0, 32'h0,        1'b1, 1'b1, 18});
        table_q.push_back('{1'b1, 8'h20, 32'h12345678, 3, 1'b0, 1'b0, 5, 32'h0,        1'b0, 1'b0, 6});
        table_q.push_back('{1'b0, 8'h20, 32'h0,        2, 1'b0, 1'b0, 2, 32'h12345678, 1'b0, 1'b0, 5});
        table_q.push_back('{1'b1, 8'h30, 32'hCAFEF00D, 0, 1'b0, 1'b1, 1, 32'h0,        1'b1, 1'b1, 18});
        table_q.push_back('{1'b0, 8'h30, 32'h0,        0, 1'b0, 1'b0, 0, 32'h0,        1'b0, 1'b0, 3});
        table_q.push_back('{1'b1, 8'h40, 32'hAAAA5555, 0, 1'b1, 1'b0, 0, 32'h0,        1'b1, 1'b0, 3});
        table_q.push_back('{1'b0, 8'h40, 32'h0,        1, 1'b0, 1'b0, 0, 32'h0,        1'b0, 1'b0, 4});

        // Reset state
        repeat (2) @(negedge pclk);
        checkOutput("reset_psel", 32'(psel_o), 32'd0);
        checkOutput("reset_penable", 32'(penable_o), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("reset_cmd_ready", 32'(cmd_ready_o), 32'd0);
        preset = 1'b0;
        @(negedge pclk);
        checkOutput("post_reset_cmd_ready", 32'(cmd_ready_o), 32'd1);

        foreach (table_q[k]) begin
            runAndCheck(table_q[k], $sformatf("vec%0d", k));
            commitRef(table_q[k]);
        end

        // Randomized commands checked against the reference memory
        for (int n = 0; n < 30; n++) begin
            vec_t v;
            v.write    = $urandom_range(0, 1) == 1;
            v.addr     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'h10 * $urandom_range(1, 4));
            v.wdata    = $urandom;
            v.waits    = $urandom_range(0, 3);
            v.err      = $urandom_range(0, 7) == 0;
            v.hang     = $urandom_range(0, 15) == 0;
            v.rdyDelay = $urandom_range(0, 3);
            v = predict(v);
            runAndCheck(v, $sformatf("rand%0d", n));
            commitRef(v);
        end

        // Back-to-back: cmd_valid held high across three writes
        begin
            int base, idx, cyc;
            bit acc;
            logic [7:0]  bbAddr [3];
            logic [31:0] bbData [3];
            vec_t rd;
            logic [31:0] rdata;
            logic        err, tmo;
            int          lat, pen, holdBad;
            for (int i = 0; i < 3; i++) begin
                bbAddr[i] = 8'h50 + 8'(i);
                bbData[i] = $urandom;
            end
            waitsCfg = 0;
            base = setupSeen;
            rsp_ready_i = 1'b1;
            @(negedge pclk);
            cmd_valid_i = 1'b1; cmd_write_i = 1'b1;
            cmd_addr_i = bbAddr[0]; cmd_wdata_i = bbData[0];
            idx = 0; cyc = 0;
            while (idx < 3 && cyc < 60) begin
                acc = cmd_ready_o;
                @(negedge pclk);
                cyc++;
                if (acc) begin
                    idx++;
                    if (idx < 3) begin
                        cmd_addr_i = bbAddr[idx]; cmd_wdata_i = bbData[idx];
                    end else cmd_valid_i = 1'b0;
                end
            end
            cmd_valid_i = 1'b0;
            repeat (5) @(negedge pclk);
            rsp_ready_i = 1'b0;
            checkOutput("b2b_accepted", 32'(idx), 32'd3);
            checkOutput("b2b_setup_phases", 32'(setupSeen - base), 32'd3);
            for (int i = 0; i < 3; i++) refMem[bbAddr[i]] = bbData[i];
            rd = '{1'b0, 8'h51, 32'h0, 0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0};
            rd = predict(rd);
            applyStimulus(rd, rdata, err, tmo, lat, pen, holdBad);
            checkOutput("b2b_readback", rdata, rd.expRdata);
            checkOutput("b2b_readback_nonzero", 32'(rdata == bbData[1]), 32'd1);
        end

        // Reset asserted during ACCESS aborts silently
        begin
            vec_t rd;
            hangCfg = 1'b1;
            @(negedge pclk);
            cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 8'h10;
            @(negedge pclk);
            cmd_valid_i = 1'b0;
            @(negedge pclk);
            checkOutput("rst_mid_in_access", 32'(penable_o), 32'd1);
            preset = 1'b1;
            @(negedge pclk);
            checkOutput("rst_mid_psel", 32'(psel_o), 32'd0);
            checkOutput("rst_mid_penable", 32'(penable_o), 32'd0);
            checkOutput("rst_mid_rsp_valid", 32'(rsp_valid_o), 32'd0);
            checkOutput("rst_mid_cmd_ready", 32'(cmd_ready_o), 32'd0);
            preset = 1'b0;
            hangCfg = 1'b0;
            @(negedge pclk);
            checkOutput("rst_release_cmd_ready", 32'(cmd_ready_o), 32'd1);
            rd = '{1'b0, 8'h10, 32'h0, 1, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0};
            rd = predict(rd);
            runAndCheck(rd, "post_rst_read");
        end

        checkOutput("apb_protocol", 32'(protoErr), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
